// File: rtl/p_shfrot_pipe.sv
// Pipelined issue/retire wrapper around a packed (lane-wise) shift/rotate barrel.
// It has an S1 operand/control register and an optional S2 result register, with valid/ready on both sides.
module p_shfrot_pipe #(
  parameter int PIPE_OUT = 1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_crs1,
  input  logic [4:0]  in_shamt,
  input  logic [2:0]  in_pw,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_illegal
);

  // One lane width: each output bit picks its source bit inside its own lane.
  function automatic logic [31:0] lane_op(input logic [31:0] x, input logic [4:0] s,
                                          input int lw, input logic rot, input logic right);
    logic [31:0] r;
    logic [4:0]  idx;
    int          jj;
    int          base;
    int          src;
    r = 32'd0;
    for (int j = 32'sd0; j < 32'sd32; j++) begin
      jj   = j % lw;
      base = j - jj;
      src  = right ? (jj + int'(s)) : (jj - int'(s));
      idx  = 5'd0;
      if (rot) begin
        idx  = 5'(base + (src & (lw - 32'sd1)));
        r[j] = x[idx];
      end else if (src >= 32'sd0 && src < lw) begin
        idx  = 5'(base + src);
        r[j] = x[idx];
      end else begin
        r[j] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] barrel(input logic [31:0] x, input logic [4:0] s,
                                         input logic [4:0] pw_oh, input logic rot,
                                         input logic right);
    logic [31:0] r;
    case (pw_oh)
      5'b00001: r = lane_op(x, s, 32'sd32, rot, right);
      5'b00010: r = lane_op(x, s, 32'sd16, rot, right);
      5'b00100: r = lane_op(x, s, 32'sd8,  rot, right);
      5'b01000: r = lane_op(x, s, 32'sd4,  rot, right);
      5'b10000: r = lane_op(x, s, 32'sd2,  rot, right);
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] decode_pw(input logic [2:0] pw);
    logic [4:0] r;
    case (pw)
      3'b000:  r = 5'b00001;
      3'b001:  r = 5'b00010;
      3'b010:  r = 5'b00100;
      3'b011:  r = 5'b01000;
      3'b100:  r = 5'b10000;
      default: r = 5'b00000;
    endcase
    return r;
  endfunction

  logic        s1_valid_r;
  logic [31:0] s1_crs1_r;
  logic [4:0]  s1_shamt_r;
  logic [4:0]  s1_pw_oh_r;
  logic        s1_rot_r;
  logic        s1_right_r;
  logic        s1_illegal_r;
  logic        s2_free_s;
  logic        s1_drain_s;
  logic        accept_s;
  logic [4:0]  pw_oh_s;
  logic [31:0] barrel_s;

  assign in_ready   = !flush && (!s1_valid_r || s2_free_s);
  assign accept_s   = in_valid && in_ready;
  assign s1_drain_s = s1_valid_r && s2_free_s;
  assign pw_oh_s    = decode_pw(in_pw);

  // S1 operand and decoded-control register; flush takes priority over everything.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      s1_valid_r   <= 1'b0;
      s1_crs1_r    <= 32'd0;
      s1_shamt_r   <= 5'd0;
      s1_pw_oh_r   <= 5'd0;
      s1_rot_r     <= 1'b0;
      s1_right_r   <= 1'b0;
      s1_illegal_r <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (accept_s) begin
        s1_valid_r <= 1'b1;
      end else if (s1_drain_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (accept_s) begin
        s1_crs1_r    <= in_crs1;
        s1_shamt_r   <= in_shamt;
        s1_pw_oh_r   <= pw_oh_s;
        s1_rot_r     <= in_op[1];
        s1_right_r   <= in_op[0];
        s1_illegal_r <= (pw_oh_s == 5'b00000);
      end
    end
  end

  // Barrel evaluated from S1; an illegal pack width yields zero.
  always_comb begin
    barrel_s = 32'd0;
    if (s1_illegal_r) begin
      barrel_s = 32'd0;
    end else begin
      barrel_s = barrel(s1_crs1_r, s1_shamt_r, s1_pw_oh_r, s1_rot_r, s1_right_r);
    end
  end

  generate
    if (PIPE_OUT != 0) begin : g_s2
      logic        s2_valid_r;
      logic [31:0] s2_result_r;
      logic        s2_illegal_r;

      assign s2_free_s   = !s2_valid_r || out_ready;
      assign out_valid   = s2_valid_r;
      assign out_result  = s2_result_r;
      assign out_illegal = s2_illegal_r;

      // S2 result register; retire and refill may happen on the same edge.
      always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
          s2_valid_r   <= 1'b0;
          s2_result_r  <= 32'd0;
          s2_illegal_r <= 1'b0;
        end else if (flush) begin
          s2_valid_r <= 1'b0;
        end else if (s1_drain_s) begin
          s2_valid_r   <= 1'b1;
          s2_result_r  <= barrel_s;
          s2_illegal_r <= s1_illegal_r;
        end else if (out_ready) begin
          s2_valid_r <= 1'b0;
        end else begin
          s2_valid_r <= s2_valid_r;
        end
      end
    end else begin : g_no_s2
      assign s2_free_s   = out_ready;
      assign out_valid   = s1_valid_r;
      assign out_result  = barrel_s;
      assign out_illegal = s1_illegal_r;
    end
  endgenerate

endmodule

// File: tb/tb_p_shfrot_pipe.sv
// Self-checking bench for p_shfrot_pipe: directed vector table, handshake corner sequences,
// and a randomized stream checked against a lane-arithmetic reference model.
module tb_p_shfrot_pipe;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_crs1;
  logic [4:0]  in_shamt;
  logic [2:0]  in_pw;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  p_shfrot_pipe #(.PIPE_OUT(1)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_crs1(in_crs1), .in_shamt(in_shamt),
    .in_pw(in_pw), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: split into lanes of width 32>>pw and apply plain integer shift/rotate per lane.
  function automatic logic [31:0] ref_op(input logic [31:0] crs1, input logic [4:0] shamt,
                                         input logic [2:0] pw, input logic [1:0] op);
    longint unsigned v, o, res, mask;
    int w, r, s;
    if (pw > 3'd4) return 32'd0;
    w    = 32 >> pw;
    s    = int'(shamt);
    mask = (64'd1 << w) - 64'd1;
    r    = s % w;
    res  = 64'd0;
    for (int l = 0; l < 32 / w; l++) begin
      v = (longint'(crs1) >> (l * w)) & mask;
      case (op)
        2'b00:   o = (s >= w) ? 64'd0 : ((v << s) & mask);
        2'b01:   o = (s >= w) ? 64'd0 : (v >> s);
        2'b10:   o = ((v << r) | (v >> (w - r))) & mask;
        default: o = ((v >> r) | (v << (w - r))) & mask;
      endcase
      res = res | (o << (l * w));
    end
    return res[31:0];
  endfunction

  task automatic drive(input logic v, input logic [31:0] c, input logic [4:0] s,
                       input logic [2:0] p, input logic [1:0] o);
    in_valid = v; in_crs1 = c; in_shamt = s; in_pw = p; in_op = o;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  pw;
    logic [31:0] crs1;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          acc;
  } exp_t;

  vec_t vecs [12];
  exp_t q [$];

  initial begin
    logic [31:0] ra, rb, rc, prev_res;
    logic        prev_stall, exp_rdy, exp_ov;
    exp_t e;

    vecs[0]  = '{2'b10, 3'b000, 32'h80000001, 5'd1,  32'h00000003, 1'b0};
    vecs[1]  = '{2'b00, 3'b001, 32'h12345678, 5'd4,  32'h23406780, 1'b0};
    vecs[2]  = '{2'b10, 3'b001, 32'h12345678, 5'd4,  32'h23416785, 1'b0};
    vecs[3]  = '{2'b10, 3'b001, 32'h12345678, 5'd20, 32'h23416785, 1'b0};
    vecs[4]  = '{2'b11, 3'b010, 32'h12345678, 5'd4,  32'h21436587, 1'b0};
    vecs[5]  = '{2'b00, 3'b011, 32'hFFFFFFFF, 5'd4,  32'h00000000, 1'b0};
    vecs[6]  = '{2'b10, 3'b100, 32'h00000001, 5'd1,  32'h00000002, 1'b0};
    vecs[7]  = '{2'b10, 3'b101, 32'hDEADBEEF, 5'd3,  32'h00000000, 1'b1};
    vecs[8]  = '{2'b01, 3'b000, 32'h80000000, 5'd31, 32'h00000001, 1'b0};
    vecs[9]  = '{2'b00, 3'b111, 32'h12345678, 5'd0,  32'h00000000, 1'b1};
    vecs[10] = '{2'b11, 3'b100, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0};
    vecs[11] = '{2'b01, 3'b010, 32'hFFFFFFFF, 5'd9,  32'h00000000, 1'b0};

    g_reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 5'd0, 3'd0, 2'd0);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_out_illegal", 32'(out_illegal), 32'd0);
    repeat (2) @(negedge g_clk);
    g_reset = 1'b0;
    #1 chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, one at a time with exact latency check.
    for (int i = 0; i < 12; i++) begin
      @(negedge g_clk);
      drive(1'b1, vecs[i].crs1, vecs[i].shamt, vecs[i].pw, vecs[i].op);
      #1 chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge g_clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1_valid", i), 32'(out_valid), 32'd0);
      @(negedge g_clk);
      chk($sformatf("vec%0d_lat2_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
    end

    // Backpressure: A and B buffered, C stalls, then all drain in order.
    ra = ref_op(32'h80000001, 5'd1, 3'b000, 2'b10);
    rb = ref_op(32'h12345678, 5'd4, 3'b001, 2'b00);
    rc = ref_op(32'h12345678, 5'd4, 3'b010, 2'b11);
    @(negedge g_clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h80000001, 5'd1, 3'b000, 2'b10);
    #1 chk("bp_accept_a", 32'(in_ready), 32'd1);
    @(negedge g_clk);
    drive(1'b1, 32'h12345678, 5'd4, 3'b001, 2'b00);
    #1 chk("bp_accept_b", 32'(in_ready), 32'd1);
    @(negedge g_clk);
    drive(1'b1, 32'h12345678, 5'd4, 3'b010, 2'b11);
    #1 chk("bp_stall_c", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_a", out_result, ra);
    @(negedge g_clk);
    #1 chk("bp_stall_c2", 32'(in_ready), 32'd0);
    chk("bp_hold_a2", out_result, ra);
    @(negedge g_clk);
    out_ready = 1'b1;
    #1 chk("bp_out_a", out_result, ra);
    chk("bp_out_a_valid", 32'(out_valid), 32'd1);
    chk("bp_accept_c", 32'(in_ready), 32'd1);
    @(negedge g_clk);
    in_valid = 1'b0;
    #1 chk("bp_out_b", out_result, rb);
    chk("bp_out_b_valid", 32'(out_valid), 32'd1);
    @(negedge g_clk);
    #1 chk("bp_out_c", out_result, rc);
    chk("bp_out_c_valid", 32'(out_valid), 32'd1);
    @(negedge g_clk);
    #1 chk("bp_drained", 32'(out_valid), 32'd0);

    // Flush with both stages full.
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 5'd1, 3'b000, 2'b00);
    @(negedge g_clk);
    drive(1'b1, 32'h22222222, 5'd2, 3'b000, 2'b00);
    @(negedge g_clk);
    flush = 1'b1;
    drive(1'b1, 32'h33333333, 5'd3, 3'b000, 2'b00);
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_cycle_valid", 32'(out_valid), 32'd1);
    @(negedge g_clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge g_clk);
      #1 chk($sformatf("flush_no_stale%0d", i), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream with a result waiting.
    @(negedge g_clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h80000001, 5'd1, 3'b000, 2'b10);
    @(negedge g_clk);
    in_valid = 1'b0;
    @(negedge g_clk);
    #1 chk("rst_pre_valid", 32'(out_valid), 32'd1);
    #1 g_reset = 1'b1;
    #1 chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_result", out_result, 32'd0);
    chk("rst_async_illegal", 32'(out_illegal), 32'd0);
    @(negedge g_clk);
    g_reset = 1'b0; out_ready = 1'b1;
    #1 chk("rst_after_valid", 32'(out_valid), 32'd0);
    chk("rst_after_in_ready", 32'(in_ready), 32'd1);

    // Randomized stream against the scoreboard, followed by a quiet drain.
    prev_stall = 1'b0; prev_res = 32'd0;
    for (int i = 0; i < 808; i++) begin
      @(negedge g_clk);
      if (i < 800) begin
        drive(($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 31)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        out_ready = ($urandom_range(0, 9) < 6);
        flush     = ($urandom_range(0, 39) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end
      #1;
      exp_rdy = !flush && ((q.size() < 2) || out_ready);
      exp_ov  = (q.size() > 0) && (i >= q[0].acc + 2);
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
      if (prev_stall) chk("rnd_stable", out_result, prev_res);
      if (exp_ov) begin
        chk("rnd_result", out_result, q[0].res);
        chk("rnd_illegal", 32'(out_illegal), 32'(q[0].ill));
        if (out_ready) void'(q.pop_front());
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_res   = out_result;
      if (in_valid && exp_rdy) begin
        e.res = ref_op(in_crs1, in_shamt, in_pw, in_op);
        e.ill = (in_pw > 3'd4);
        e.acc = i;
        q.push_back(e);
      end
      if (flush) q.delete();
    end
    chk("rnd_all_delivered", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
